// File: rtl/timing_req_initiator_pkg.sv
// Shared types and defaults for the req/out/clr sticky-flag initiator.
package timing_req_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CLR,
    DRAIN,
    ERR
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/timing_req_initiator_if.sv
// Control, responder and status signals of the initiator, grouped for port reuse.
interface timing_req_initiator_if #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned LAT_WIDTH   = 8
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] num_reqs;
  logic                   resp;
  logic                   req;
  logic                   clr;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;
  logic [COUNT_WIDTH-1:0] completed;
  logic [LAT_WIDTH-1:0]   last_latency;

  modport master (
    input  start, num_reqs, resp,
    output req, clr, busy, done, timeout_err, completed, last_latency
  );

  modport slave (
    output start, num_reqs, resp,
    input  req, clr, busy, done, timeout_err, completed, last_latency
  );
endinterface

// File: rtl/timing_req_initiator_wait_counter.sv
// Saturating wait counter shared by the REQ and DRAIN waits.
module wait_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             hit
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && count != LAST)
      count <= count + WIDTH'(1);
  end

  // The edge on which hit is seen is the TIMEOUT-th waiting edge.
  assign hit = (count == LAST);
endmodule

// File: rtl/timing_req_initiator.sv
// Initiator FSM: issues num_reqs req/clr transactions, tracks count, latency and timeouts.
module timing_req_initiator
  import timing_req_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned LAT_WIDTH   = 8,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst,
  timing_req_initiator_if.master bus
);
  state_t                 state, state_n;
  logic [COUNT_WIDTH-1:0] remaining, remaining_n;
  logic [COUNT_WIDTH-1:0] completed_q, completed_n;
  logic [LAT_WIDTH-1:0]   latency_q, latency_n;
  logic                   req_q, clr_q, busy_q, done_q, err_q, done_n;
  logic                   wait_clear, wait_en, wait_hit;
  logic [LAT_WIDTH-1:0]   wait_cnt;

  wait_counter #(.WIDTH(LAT_WIDTH), .TIMEOUT(TIMEOUT)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear),
    .enable (wait_en),
    .count  (wait_cnt),
    .hit    (wait_hit)
  );

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    completed_n = completed_q;
    latency_n   = latency_q;
    done_n      = 1'b0;
    wait_clear  = 1'b0;
    wait_en     = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (bus.start) begin
          completed_n = '0;
          if (bus.num_reqs != '0) begin
            state_n     = REQ;
            remaining_n = bus.num_reqs;
            wait_clear  = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.resp) begin
          state_n   = CLR;
          latency_n = wait_cnt + LAT_WIDTH'(1);
        end else if (wait_hit) begin
          state_n = ERR;
        end else begin
          wait_en = 1'b1;
        end
      end
      CLR: begin
        state_n    = DRAIN;
        wait_clear = 1'b1;
      end
      DRAIN: begin
        if (!bus.resp) begin
          completed_n = completed_q + COUNT_WIDTH'(1);
          remaining_n = remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n    = REQ;
            wait_clear = 1'b1;
          end
        end else if (wait_hit) begin
          state_n = ERR;
        end else begin
          wait_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output flops are loaded from the next-state decode so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      completed_q <= '0;
      latency_q   <= '0;
      req_q       <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      remaining   <= remaining_n;
      completed_q <= completed_n;
      latency_q   <= latency_n;
      req_q       <= (state_n == REQ);
      clr_q       <= (state_n == CLR);
      busy_q      <= (state_n == REQ) || (state_n == CLR) || (state_n == DRAIN);
      done_q      <= done_n;
      err_q       <= (state_n == ERR);
    end
  end

  assign bus.req          = req_q;
  assign bus.clr          = clr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout_err  = err_q;
  assign bus.completed    = completed_q;
  assign bus.last_latency = latency_q;
endmodule

// File: tb/tb_timing_req_initiator.sv
// Scoreboard bench for timing_req_initiator against a programmable behavioural responder.
module tb_timing_req_initiator;
  localparam int TO = 16;

  typedef struct {
    bit is_err;
    int comp;
    int lat;
    int cyc;
    int busy_cycles;
    int req_pulses;
    int clr_pulses;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mode    = 0;   // 0: normal responder, 1: out stuck low, 2: out stuck high
  int   dly     = 0;   // extra cycles before out rises
  int   model_lat = 0;
  logic out_q;
  int   dly_cnt;
  exp_t sb[$];

  timing_req_initiator_if #(.COUNT_WIDTH(8), .LAT_WIDTH(8)) bus ();

  timing_req_initiator #(.COUNT_WIDTH(8), .LAT_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst || mode != 0) begin
      out_q   <= 1'b0;
      dly_cnt <= 0;
    end else begin
      if (bus.req && !out_q) begin
        if (dly_cnt == dly) out_q <= 1'b1;
        else dly_cnt <= dly_cnt + 1;
      end else begin
        dly_cnt <= 0;
      end
      if (bus.clr) out_q <= 1'b0;
    end
  end

  assign bus.resp = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : out_q;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: collects per-batch activity and compares on done / error rise.
  int   busy_cnt = 0, reqp = 0, clrp = 0;
  logic req_prev = 0, clr_prev = 0, err_prev = 0;
  bit   excl_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; reqp = 0; clrp = 0;
      req_prev = 0; clr_prev = 0; err_prev = 0; excl_bad = 0;
    end else begin
      exp_t e;
      if (bus.busy) busy_cnt++;
      if (bus.req && !req_prev) reqp++;
      if (bus.clr && !clr_prev) clrp++;
      if (bus.req && bus.clr) excl_bad = 1;
      if (bus.done || (bus.timeout_err && !err_prev)) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          check("event_kind_err", int'(bus.timeout_err), int'(e.is_err));
          check("event_cycle", cyc, e.cyc);
          check("completed", int'(bus.completed), e.comp);
          check("last_latency", int'(bus.last_latency), e.lat);
          check("busy_cycles", busy_cnt, e.busy_cycles);
          check("req_pulses", reqp, e.req_pulses);
          check("clr_pulses", clrp, e.clr_pulses);
          check("req_clr_exclusive", int'(excl_bad), 0);
          if (e.is_err) begin
            check("err_busy_low", int'(bus.busy), 0);
            check("err_req_low", int'(bus.req), 0);
          end
        end
        busy_cnt = 0; reqp = 0; clrp = 0; excl_bad = 0;
      end
      req_prev = bus.req;
      clr_prev = bus.clr;
      err_prev = bus.timeout_err;
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("batch_timeout", 1, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Expected outcome of a batch from the protocol rules alone.
  task automatic run_batch(input int n, input int d, input int m, input bit spurious);
    exp_t e;
    @(negedge clk);
    mode = m;
    dly  = d;
    bus.start    = 1'b1;
    bus.num_reqs = 8'(n);
    e.cyc = cyc + 1;
    e.req_pulses = 0; e.clr_pulses = 0; e.is_err = 0; e.comp = 0;
    if (n == 0) begin
      e.lat = model_lat;
    end else if (m == 0) begin
      e.cyc += (4 + d) * n;
      e.comp = n; e.lat = d + 2; e.req_pulses = n; e.clr_pulses = n;
    end else if (m == 1) begin
      e.is_err = 1; e.cyc += TO; e.lat = model_lat; e.req_pulses = 1;
    end else begin
      e.is_err = 1; e.cyc += TO + 2; e.lat = 1; e.req_pulses = 1; e.clr_pulses = 1;
    end
    e.busy_cycles = e.cyc - (cyc + 1);
    model_lat = e.lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    if (spurious && n > 0) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.num_reqs = 8'($urandom_range(1, 9));
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_empty();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.num_reqs = '0;
    #1;
    check("rst_req", int'(bus.req), 0);
    check("rst_clr", int'(bus.clr), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.timeout_err), 0);
    check("rst_completed", int'(bus.completed), 0);
    check("rst_latency", int'(bus.last_latency), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_batch(1, 0, 0, 0);
    run_batch(3, 0, 0, 0);
    run_batch(1, 3, 0, 0);
    run_batch(2, 0, 1, 0);
    check("err_sticky", int'(bus.timeout_err), 1);
    run_batch(1, 0, 0, 0);
    check("err_cleared", int'(bus.timeout_err), 0);
    run_batch(0, 0, 0, 0);
    run_batch(3, 1, 0, 1);
    run_batch(1, 0, 2, 0);
    run_batch(0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      run_batch(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 0,
                bit'($urandom_range(0, 1)));

    // Asynchronous reset while waiting in REQ.
    @(negedge clk);
    mode = 0; dly = 5;
    bus.start = 1'b1; bus.num_reqs = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_req", int'(bus.req), 1);
    rst = 1'b1;
    #1;
    check("async_rst_req", int'(bus.req), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_clr", int'(bus.clr), 0);
    check("async_rst_completed", int'(bus.completed), 0);
    sb.delete();
    model_lat = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_batch(2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
